// File: rtl/vga_timing_pkg.sv
// Shared timing types and 640x480@60 constants for the horizontal/vertical
// sync timing counters.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    R_ACTIVE = 2'd0,
    R_FRONT  = 2'd1,
    R_SYNC   = 2'd2,
    R_BACK   = 2'd3
  } region_t;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;

  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;

endpackage

// File: rtl/sync_timing_counter.sv
// One axis of a raster timing generator: position counter, region FSM, and
// registered active/sync/last/wrap flags. Define SYNC_TIMING_COUNTER_FRAME_EN to add a frame counter.
module sync_timing_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE   = 480,
  parameter int FRONT    = 10,
  parameter int SYNC     = 2,
  parameter int BACK     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             use_enable,
  input  logic             cnt_en,
  output logic [CNT_W-1:0] count,
  output logic             active,
  output logic             sync,
  output logic             last,
  output logic             wrap
`ifdef SYNC_TIMING_COUNTER_FRAME_EN
  ,
  output logic [15:0]      frame
`endif
);

  localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

  generate
    if (ACTIVE == 0) begin : g_err_active
      $error("sync_timing_counter: ACTIVE must be nonzero");
    end
    if (CNT_W < 63 && (longint'(TOTAL) - 64'sd1) >= (64'sd1 <<< CNT_W)) begin : g_err_width
      $error("sync_timing_counter: TOTAL-1 does not fit in CNT_W bits");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] B_FRONT  = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] B_SYNC   = CNT_W'(ACTIVE + FRONT);
  localparam logic [CNT_W-1:0] B_BACK   = CNT_W'(ACTIVE + FRONT + SYNC);
  localparam logic             LAST_RST = (TOTAL == 1);

  logic             advance;
  logic [CNT_W-1:0] count_d;
  region_t          region_q;
  region_t          region_d;

  // Boundaries are tested highest-first so coincident boundaries from
  // zero-span regions land directly in the first non-empty region.
  always_comb begin
    advance  = use_enable & cnt_en;
    count_d  = (count == LAST_C) ? '0 : count + CNT_W'(1);
    region_d = region_q;
    if (count_d == '0)
      region_d = R_ACTIVE;
    else if (BACK != 0 && count_d == B_BACK)
      region_d = R_BACK;
    else if (SYNC != 0 && count_d == B_SYNC)
      region_d = R_SYNC;
    else if (FRONT != 0 && count_d == B_FRONT)
      region_d = R_FRONT;
  end

  // Flags are derived from the next count so they line up with count itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      region_q <= R_ACTIVE;
      active   <= 1'b1;
      sync     <= ~SYNC_POL;
      last     <= LAST_RST;
      wrap     <= 1'b0;
    end else begin
      wrap <= advance && (count == LAST_C);
      if (advance) begin
        count    <= count_d;
        region_q <= region_d;
        active   <= (region_d == R_ACTIVE);
        sync     <= (region_d == R_SYNC) ? SYNC_POL : ~SYNC_POL;
        last     <= (count_d == LAST_C);
      end
    end
  end

`ifdef SYNC_TIMING_COUNTER_FRAME_EN
  always_ff @(posedge clk) begin
    if (rst)
      frame <= '0;
    else if (advance && count == LAST_C)
      frame <= frame + 16'd1;
  end
`endif

endmodule

// File: tb/tb_sync_timing_counter.sv
// Directed bench for sync_timing_counter: default vertical timing, a
// FRONT=0/active-high-sync variant, and a single-count (TOTAL=1) instance.
module tb_sync_timing_counter;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, use_enable, cnt_en;
  logic [15:0] count, count2;
  logic        active, sync, last, wrap;
  logic        active2, sync2, last2, wrap2;
  logic        rst3, ue3, ce3;
  logic [3:0]  count3;
  logic        active3, sync3, last3, wrap3;
`ifdef SYNC_TIMING_COUNTER_FRAME_EN
  logic [15:0] frame, frame2, frame3;
`endif

  int total = 0;
  int bad   = 0;
  int m     = 0;
  int m2    = 0;
  logic ew, ew2;

  sync_timing_counter dut (
    .clk(clk), .rst(rst), .use_enable(use_enable), .cnt_en(cnt_en),
    .count(count), .active(active), .sync(sync), .last(last), .wrap(wrap)
`ifdef SYNC_TIMING_COUNTER_FRAME_EN
    , .frame(frame)
`endif
  );

  sync_timing_counter #(.FRONT(0), .SYNC_POL(1'b1)) dut2 (
    .clk(clk), .rst(rst), .use_enable(use_enable), .cnt_en(cnt_en),
    .count(count2), .active(active2), .sync(sync2), .last(last2), .wrap(wrap2)
`ifdef SYNC_TIMING_COUNTER_FRAME_EN
    , .frame(frame2)
`endif
  );

  sync_timing_counter #(.ACTIVE(1), .FRONT(0), .SYNC(0), .BACK(0), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst3), .use_enable(ue3), .cnt_en(ce3),
    .count(count3), .active(active3), .sync(sync3), .last(last3), .wrap(wrap3)
`ifdef SYNC_TIMING_COUNTER_FRAME_EN
    , .frame(frame3)
`endif
  );

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic region_t exp_region(int c, int a, int f, int s);
    if (c < a)              return R_ACTIVE;
    else if (c < a + f)     return R_FRONT;
    else if (c < a + f + s) return R_SYNC;
    else                    return R_BACK;
  endfunction

  // Default instance: TOTAL=525, sync low at 490..491.
  // dut2: TOTAL=515, sync high at 480..481.
  task automatic tick(input logic r, input logic ue, input logic ce);
    rst = r; use_enable = ue; cnt_en = ce;
    @(posedge clk); #1;
    ew = 1'b0; ew2 = 1'b0;
    if (r) begin
      m = 0; m2 = 0;
    end else if (ue && ce) begin
      ew  = (m == 524);
      ew2 = (m2 == 514);
      m   = (m == 524) ? 0 : m + 1;
      m2  = (m2 == 514) ? 0 : m2 + 1;
    end
    check("count",   count,  m);
    check("active",  active, m < 480);
    check("sync",    sync,   !(m >= 490 && m < 492));
    check("last",    last,   m == 524);
    check("wrap",    wrap,   ew);
    check("region",  dut.region_q, exp_region(m, 480, 10, 2));
    check("count2",  count2,  m2);
    check("active2", active2, m2 < 480);
    check("sync2",   sync2,   m2 >= 480 && m2 < 482);
    check("last2",   last2,   m2 == 514);
    check("wrap2",   wrap2,   ew2);
    check("region2", dut2.region_q, exp_region(m2, 480, 0, 2));
  endtask

  task automatic tick3(input logic r, input logic ue, input logic ce);
    rst3 = r; ue3 = ue; ce3 = ce;
    @(posedge clk); #1;
    check("count3",  count3,  0);
    check("last3",   last3,   1);
    check("active3", active3, 1);
    check("sync3",   sync3,   1);
    check("wrap3",   wrap3,   !r && ue && ce);
  endtask

  initial begin
    rst3 = 1'b1; ue3 = 1'b0; ce3 = 1'b0;

    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
`ifdef SYNC_TIMING_COUNTER_FRAME_EN
    check("frame_rst", frame, 0);
`endif

    // one full frame of the default instance, first advance gives count=1
    for (int k = 1; k <= 525; k++) tick(1'b0, 1'b1, 1'b1);
    check("count_after_frame",  count,  0);
    check("count2_after_frame", count2, 10);

    for (int k = 0; k < 524; k++) tick(1'b0, 1'b1, 1'b1);
    check("count_at_last", count, 524);

    // held at the last count: nothing moves, wrap never fires
    for (int i = 0; i < 100; i++) tick(1'b0, (i % 2) == 1, 1'b0);
    for (int i = 0; i < 3; i++)   tick(1'b0, 1'b0, 1'b1);

    // reset wins over the pending wrap
    tick(1'b1, 1'b1, 1'b1);
    check("rst_wrap_low", wrap, 0);
    tick(1'b0, 1'b1, 1'b1);
    check("first_adv_after_rst", count, 1);

    for (int k = 0; k < 524 + 2 * 525; k++) tick(1'b0, 1'b1, 1'b1);
    check("count_after_3_frames", count, 0);
`ifdef SYNC_TIMING_COUNTER_FRAME_EN
    check("frame_3", frame, 3);
    check("frame2_3", frame2, 3);
`endif

    use_enable = 1'b0; cnt_en = 1'b0; rst = 1'b0;
    tick3(1'b1, 1'b1, 1'b1);
    tick3(1'b0, 1'b1, 1'b1);
    tick3(1'b0, 1'b1, 1'b0);
`ifdef SYNC_TIMING_COUNTER_FRAME_EN
    check("frame3_1", frame3, 1);
    for (int k = 0; k < 65534; k++) tick3(1'b0, 1'b1, 1'b1);
    check("frame3_max", frame3, 65535);
    tick3(1'b0, 1'b1, 1'b1);
    check("frame3_rollover", frame3, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_timing_counter.md
SYNC_TIMING_COUNTER -- requirements
Module: sync_timing_counter

Interface
REQ-001 SHALL have parameter ACTIVE, default 480: visible count span.
REQ-002 SHALL have parameter FRONT, default 10: front-porch span.
REQ-003 SHALL have parameter SYNC, default 2: sync-pulse span.
REQ-004 SHALL have parameter BACK, default 33: back-porch span.
REQ-005 SHALL have parameter SYNC_POL, default 0: asserted level of sync (0 = active-low).
REQ-006 SHALL have parameter CNT_W, default 16: width of count.
REQ-007 SHALL have port clk  in  1: single clock; all logic on posedge.
REQ-008 SHALL have port rst  in  1: reset, synchronous and active-high.
REQ-009 SHALL have port use_enable  in  1: pixel-rate tick; no state changes when low.
REQ-010 SHALL have port cnt_en  in  1: carry-in from the lower-order counter; advance only when use_enable and cnt_en are both high.
REQ-011 SHALL have port count  out  CNT_W: current position, 0..TOTAL-1.
REQ-012 SHALL have port active  out  1: high while count < ACTIVE.
REQ-013 SHALL have port sync  out  1: equals SYNC_POL while in the sync region, else ~SYNC_POL.
REQ-014 SHALL have port last  out  1: high while count == TOTAL-1.
REQ-015 SHALL have port wrap  out  1: one-cycle pulse on the advance from TOTAL-1 to 0 (carry-out).

Function
REQ-016 TOTAL SHALL equal ACTIVE+FRONT+SYNC+BACK; count SHALL take exactly TOTAL distinct values (0..TOTAL-1, never TOTAL).
REQ-017 On an advance, count SHALL increment by 1, or go to 0 when count == TOTAL-1.
REQ-018 SHALL keep a registered region FSM: R_ACTIVE -> R_FRONT -> R_SYNC -> R_BACK -> R_ACTIVE.
REQ-019 Transitions SHALL occur on the advance into counts ACTIVE, ACTIVE+FRONT, ACTIVE+FRONT+SYNC and 0, respectively.
REQ-020 A region whose span parameter is 0 SHALL be skipped without spending any cycle in it.
REQ-021 active, sync and last SHALL be registered and SHALL describe the same count value in the same cycle (zero skew relative to count).
REQ-022 wrap SHALL be high for exactly the one clk cycle following the advancing edge from TOTAL-1 and SHALL be low otherwise, including while held.
REQ-023 With use_enable high and cnt_en low, all outputs SHALL hold and wrap SHALL be low.
REQ-024 Arithmetic SHALL be performed at CNT_W bits; elaboration SHALL fail if TOTAL-1 does not fit in CNT_W or if ACTIVE == 0.

Reset
REQ-025 While rst is high at a clk edge, the block SHALL load: count=0, region=R_ACTIVE, active=1, sync=~SYNC_POL, last=0 (or 1 if TOTAL==1), wrap=0.
REQ-026 rst SHALL take priority over use_enable and cnt_en, including mid-frame and on a would-be wrap cycle.
REQ-027 The first advance after rst deasserts SHALL produce count=1.

Configuration
REQ-028 With SYNC_TIMING_COUNTER_FRAME_EN defined, SHALL add output frame (16 bits):
- reset to 0
- incremented on each wrap
- wraps modulo 2^16
REQ-029 Without SYNC_TIMING_COUNTER_FRAME_EN, the frame port and its register SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 Package vga_timing_pkg SHALL hold:
- the region enum (R_ACTIVE, R_FRONT, R_SYNC, R_BACK)
- 640x480@60 constants: H 640/16/96/48, V 480/10/2/33
REQ-031 SHALL be a single module with no sub-modules; horizontal and vertical instances SHALL be chained at the top level (vertical cnt_en = horizontal wrap).

Verification
REQ-032 Default parameters; use_enable=cnt_en=1 for 525 advances -> count runs 0..524 then 0; wrap pulses once; last high only at 524.
REQ-033 Default parameters; step through counts 479/480/489/490/491/492 -> active falls at 480; sync low exactly at counts 490-491.
REQ-034 use_enable toggling 1/0 and cnt_en=0 for 100 cycles -> count, region and all outputs frozen; wrap=0.
REQ-035 rst asserted at count=524 with an advance pending -> count=0, wrap=0, active=1 next cycle.
REQ-036 FRONT=0, SYNC_POL=1 -> region goes R_ACTIVE->R_SYNC at count 480; sync high at counts 480-481.
REQ-037 With SYNC_TIMING_COUNTER_FRAME_EN defined, 3 full frames -> frame=3; with frame preset to 65535, next wrap -> frame=0.
